// File: rtl/clk_pkg.sv
// Shared types and constants for the clock period meter.
package clk_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, STALLED} meter_state_t;

  // Smallest half-period a clk_divider accepts.
  localparam int MIN_HALF_PERIOD = 1;

endpackage

// File: rtl/clk_period_meter_if.sv
// Measurement bus: the square wave in, the measured half-period and status flags out.
interface clk_period_meter_if #(
  parameter int WIDTH = 16
);

  logic             meas_in;
  logic [WIDTH-1:0] half_period;
  logic             valid;
  logic             locked;
  logic             timeout;

  modport master (
    input  meas_in,
    output half_period,
    output valid,
    output locked,
    output timeout
  );

  modport slave (
    output meas_in,
    input  half_period,
    input  valid,
    input  locked,
    input  timeout
  );

endinterface

// File: rtl/counter.sv
// Up-counter with synchronous clear and count enable.
module counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous input, followed by rise/fall pulse detection.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_level;

  assign sync_level = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_level;
    end
  end

  assign rise = sync_level & ~prev_q;
  assign fall = ~sync_level & prev_q;

endmodule

// File: rtl/geq_comparator.sv
// Unsigned a >= b comparator.
module geq_comparator #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             geq
);

  assign geq = (a >= b);

endmodule

// File: rtl/clk_period_meter.sv
// Measures the half-period of a slow square wave in clk cycles, in clk_divider encoding,
// and reports lock (stable rate) and timeout (signal lost).
module clk_period_meter
  import clk_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TOL         = 1,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  clk_period_meter_if.master        bus
);

  localparam int               SW      = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] MIN_HP  = WIDTH'(MIN_HALF_PERIOD);
  localparam logic [SW-1:0]    LOCK_SW = SW'(LOCK_COUNT);

  meter_state_t        state;
  logic                rise;
  logic                fall;
  logic                meas_edge;
  logic [WIDTH-1:0]    cnt;
  logic                sat;
  logic [WIDTH-1:0]    half_period_q;
  logic                valid_q;
  logic                locked_q;
  logic                timeout_q;
  logic [SW-1:0]       stable_cnt;
  logic [SW-1:0]       stable_next;
  logic                prev_ok;
  logic [WIDTH-1:0]    new_hp;
  logic signed [WIDTH:0] delta;
  logic [WIDTH:0]      abs_delta;
  logic                stable_hit;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(bus.meas_in),
    .rise    (rise),
    .fall    (fall)
  );

  assign meas_edge = rise | fall;

  // Counting stops at all-ones so a lost signal never wraps into a bogus short period.
  counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (meas_edge),
    .en   (~sat),
    .count(cnt)
  );

  geq_comparator #(
    .WIDTH(WIDTH)
  ) u_sat_cmp (
    .a  (cnt),
    .b  (CNT_MAX),
    .geq(sat)
  );

  // cnt at an edge already equals edge-to-edge cycles minus one.
  assign new_hp    = (cnt < MIN_HP) ? MIN_HP : cnt;
  assign delta     = $signed({1'b0, new_hp}) - $signed({1'b0, half_period_q});
  assign abs_delta = delta[WIDTH] ? $unsigned(-delta) : $unsigned(delta);
  assign stable_hit = prev_ok && (abs_delta <= (WIDTH+1)'(TOL));

  always_comb begin
    stable_next = '0;
    if (stable_hit) begin
      stable_next = (stable_cnt == LOCK_SW) ? stable_cnt : stable_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      half_period_q <= '0;
      valid_q       <= 1'b0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
      stable_cnt    <= '0;
      prev_ok       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (meas_edge) state <= ARMED;
        end
        ARMED: begin
          if (meas_edge) begin
            state <= sat ? ARMED : MEASURE;
          end else if (sat) begin
            state      <= STALLED;
            timeout_q  <= 1'b1;
            locked_q   <= 1'b0;
            stable_cnt <= '0;
            prev_ok    <= 1'b0;
          end
        end
        MEASURE: begin
          // An edge arriving on a saturated count is not a trustworthy period: re-arm.
          if (meas_edge && sat) begin
            state      <= ARMED;
            locked_q   <= 1'b0;
            stable_cnt <= '0;
            prev_ok    <= 1'b0;
          end else if (meas_edge) begin
            half_period_q <= new_hp;
            valid_q       <= 1'b1;
            stable_cnt    <= stable_next;
            locked_q      <= (stable_next == LOCK_SW);
            prev_ok       <= 1'b1;
          end else if (sat) begin
            state      <= STALLED;
            timeout_q  <= 1'b1;
            locked_q   <= 1'b0;
            stable_cnt <= '0;
            prev_ok    <= 1'b0;
          end
        end
        STALLED: begin
          if (meas_edge) begin
            state     <= ARMED;
            timeout_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.half_period = half_period_q;
  assign bus.valid       = valid_q;
  assign bus.locked      = locked_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized bench for clk_period_meter checked against an event-level reference model.
module tb_clk_period_meter;

  localparam int W          = 8;
  localparam int SYNC       = 2;
  localparam int TOL        = 1;
  localparam int LOCK_COUNT = 4;
  localparam int LAT        = SYNC + 1;
  localparam int SAT_GAP    = 1 << W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  clk_period_meter_if #(.WIDTH(W)) mif ();

  clk_period_meter #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (mif.master)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Stimulus generator: toggles meas_in every gen_lo..gen_hi cycles while gen_on.
  bit gen_on = 1'b0;
  int gen_lo = 10;
  int gen_hi = 10;
  int cd     = 1;
  int tog_count = 0;
  int n      = 0;

  // Reference model: edges are replayed LAT samples after the toggle that causes them.
  int         pend[$];
  int         hist[$];
  int         edges     = 0;
  int         last_edge = 0;
  bit         exp_valid   = 1'b0;
  bit         exp_locked  = 1'b0;
  bit         exp_timeout = 1'b0;
  logic [W-1:0] exp_hp  = '0;

  function automatic bit hist_locked();
    int s;
    int d;
    s = hist.size();
    if (s < LOCK_COUNT + 1) return 1'b0;
    for (int i = s - LOCK_COUNT; i < s; i++) begin
      d = hist[i] - hist[i-1];
      if (d < 0) d = -d;
      if (d > TOL) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_reset();
    pend.delete();
    hist.delete();
    edges       = 0;
    exp_valid   = 1'b0;
    exp_locked  = 1'b0;
    exp_timeout = 1'b0;
    exp_hp      = '0;
  endfunction

  function automatic void model_step();
    int gap;
    int hp;
    exp_valid = 1'b0;
    if (pend.size() > 0 && pend[0] == n) begin
      void'(pend.pop_front());
      gap       = n - last_edge;
      last_edge = n;
      if (edges == 0) begin
        edges = 1;
      end else if (exp_timeout || gap >= SAT_GAP) begin
        exp_timeout = 1'b0;
        exp_locked  = 1'b0;
        edges       = 1;
        hist.delete();
      end else if (edges == 1) begin
        edges = 2;
      end else begin
        hp = (gap - 1 < 1) ? 1 : gap - 1;
        exp_hp    = W'(hp);
        exp_valid = 1'b1;
        hist.push_back(hp);
        if (hist.size() > 8) void'(hist.pop_front());
        exp_locked = hist_locked();
      end
    end else if (edges > 0 && !exp_timeout && (n - last_edge) >= SAT_GAP) begin
      exp_timeout = 1'b1;
      exp_locked  = 1'b0;
      hist.delete();
    end
  endfunction

  // One clock of stimulus: sample point at the falling edge, model advance, then drive.
  task automatic tick();
    @(negedge clk);
    n++;
    model_step();
    if (gen_on) begin
      cd--;
      if (cd <= 0) begin
        mif.meas_in = ~mif.meas_in;
        tog_count++;
        pend.push_back(n + LAT);
        cd = $urandom_range(gen_hi, gen_lo);
      end
    end
  endtask

  task automatic test_reset();
    mif.meas_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({mif.valid, mif.locked, mif.timeout, mif.half_period} !== {3'b000, {W{1'b0}}}) begin
      mismatched++;
      $display("FAIL reset_outputs got v/l/t=%b%b%b hp=%0d want 000 hp=0",
               mif.valid, mif.locked, mif.timeout, mif.half_period);
    end
    repeat (3) @(negedge clk);
    compared++;
    if ({mif.valid, mif.locked, mif.timeout, mif.half_period} !== {3'b000, {W{1'b0}}}) begin
      mismatched++;
      $display("FAIL reset_held got v/l/t=%b%b%b hp=%0d want 000 hp=0",
               mif.valid, mif.locked, mif.timeout, mif.half_period);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_steady();
    gen_on = 1'b1; gen_lo = 10; gen_hi = 10; cd = 1;
    repeat (150) begin
      tick();
      compared++;
      if ({mif.valid, mif.locked, mif.timeout} !== {exp_valid, exp_locked, exp_timeout}) begin
        mismatched++;
        $display("FAIL steady_flags n=%0d got v/l/t=%b%b%b want %b%b%b", n,
                 mif.valid, mif.locked, mif.timeout, exp_valid, exp_locked, exp_timeout);
      end
      compared++;
      if (mif.half_period !== exp_hp) begin
        mismatched++;
        $display("FAIL steady_hp n=%0d got %0d want %0d", n, mif.half_period, exp_hp);
      end
    end
    compared++;
    if (mif.locked !== 1'b1 || mif.half_period !== W'(9)) begin
      mismatched++;
      $display("FAIL steady_lock got locked=%b hp=%0d want locked=1 hp=9", mif.locked, mif.half_period);
    end
  endtask

  task automatic test_rate_change();
    gen_lo = 21; gen_hi = 21;
    repeat (200) begin
      tick();
      compared++;
      if ({mif.valid, mif.locked, mif.timeout} !== {exp_valid, exp_locked, exp_timeout}) begin
        mismatched++;
        $display("FAIL rate_flags n=%0d got v/l/t=%b%b%b want %b%b%b", n,
                 mif.valid, mif.locked, mif.timeout, exp_valid, exp_locked, exp_timeout);
      end
      compared++;
      if (mif.half_period !== exp_hp) begin
        mismatched++;
        $display("FAIL rate_hp n=%0d got %0d want %0d", n, mif.half_period, exp_hp);
      end
    end
    compared++;
    if (mif.locked !== 1'b1 || mif.half_period !== W'(20)) begin
      mismatched++;
      $display("FAIL rate_relock got locked=%b hp=%0d want locked=1 hp=20", mif.locked, mif.half_period);
    end
  endtask

  task automatic test_jitter();
    gen_lo = 11; gen_hi = 12;
    repeat (200) begin
      tick();
      compared++;
      if ({mif.valid, mif.locked, mif.timeout} !== {exp_valid, exp_locked, exp_timeout}) begin
        mismatched++;
        $display("FAIL jitter_flags n=%0d got v/l/t=%b%b%b want %b%b%b", n,
                 mif.valid, mif.locked, mif.timeout, exp_valid, exp_locked, exp_timeout);
      end
      compared++;
      if (mif.half_period !== exp_hp) begin
        mismatched++;
        $display("FAIL jitter_hp n=%0d got %0d want %0d", n, mif.half_period, exp_hp);
      end
    end
    compared++;
    if (mif.locked !== 1'b1) begin
      mismatched++;
      $display("FAIL jitter_lock got locked=%b want 1", mif.locked);
    end
    gen_lo = 14; gen_hi = 14;
    repeat (30) begin
      tick();
      compared++;
      if ({mif.valid, mif.locked, mif.timeout} !== {exp_valid, exp_locked, exp_timeout}) begin
        mismatched++;
        $display("FAIL jump_flags n=%0d got v/l/t=%b%b%b want %b%b%b", n,
                 mif.valid, mif.locked, mif.timeout, exp_valid, exp_locked, exp_timeout);
      end
      compared++;
      if (mif.half_period !== exp_hp) begin
        mismatched++;
        $display("FAIL jump_hp n=%0d got %0d want %0d", n, mif.half_period, exp_hp);
      end
    end
    compared++;
    if (mif.locked !== 1'b0) begin
      mismatched++;
      $display("FAIL jump_unlock got locked=%b want 0", mif.locked);
    end
  endtask

  task automatic test_timeout();
    int start;
    logic [W-1:0] held;
    // A gap of exactly 2^W cycles saturates the counter on the same cycle the edge lands.
    gen_lo = SAT_GAP; gen_hi = SAT_GAP;
    start = tog_count;
    for (int i = 0; i < 600 && tog_count < start + 2; i++) begin
      tick();
      compared++;
      if ({mif.valid, mif.locked, mif.timeout} !== {exp_valid, exp_locked, exp_timeout}) begin
        mismatched++;
        $display("FAIL satgap_flags n=%0d got v/l/t=%b%b%b want %b%b%b", n,
                 mif.valid, mif.locked, mif.timeout, exp_valid, exp_locked, exp_timeout);
      end
    end
    gen_on = 1'b0;
    held = exp_hp;
    repeat (300) begin
      tick();
      compared++;
      if ({mif.valid, mif.locked, mif.timeout} !== {exp_valid, exp_locked, exp_timeout}) begin
        mismatched++;
        $display("FAIL hold_flags n=%0d got v/l/t=%b%b%b want %b%b%b", n,
                 mif.valid, mif.locked, mif.timeout, exp_valid, exp_locked, exp_timeout);
      end
    end
    compared++;
    if (mif.timeout !== 1'b1 || mif.locked !== 1'b0 || mif.half_period !== held) begin
      mismatched++;
      $display("FAIL timeout_state got t=%b l=%b hp=%0d want t=1 l=0 hp=%0d",
               mif.timeout, mif.locked, mif.half_period, held);
    end
    gen_on = 1'b1; gen_lo = 20; gen_hi = 20; cd = 1;
    repeat (80) begin
      tick();
      compared++;
      if ({mif.valid, mif.locked, mif.timeout} !== {exp_valid, exp_locked, exp_timeout}) begin
        mismatched++;
        $display("FAIL recover_flags n=%0d got v/l/t=%b%b%b want %b%b%b", n,
                 mif.valid, mif.locked, mif.timeout, exp_valid, exp_locked, exp_timeout);
      end
      compared++;
      if (mif.half_period !== exp_hp) begin
        mismatched++;
        $display("FAIL recover_hp n=%0d got %0d want %0d", n, mif.half_period, exp_hp);
      end
    end
  endtask

  task automatic test_reset_mid();
    gen_lo = 15; gen_hi = 15;
    repeat (47) tick();
    @(negedge clk);
    rst_n = 1'b0;
    mif.meas_in = 1'b0;
    #1;
    compared++;
    if ({mif.valid, mif.locked, mif.timeout, mif.half_period} !== {3'b000, {W{1'b0}}}) begin
      mismatched++;
      $display("FAIL midreset_async got v/l/t=%b%b%b hp=%0d want 000 hp=0",
               mif.valid, mif.locked, mif.timeout, mif.half_period);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cd = 4;
    repeat (120) begin
      tick();
      compared++;
      if ({mif.valid, mif.locked, mif.timeout} !== {exp_valid, exp_locked, exp_timeout}) begin
        mismatched++;
        $display("FAIL midreset_flags n=%0d got v/l/t=%b%b%b want %b%b%b", n,
                 mif.valid, mif.locked, mif.timeout, exp_valid, exp_locked, exp_timeout);
      end
      compared++;
      if (mif.half_period !== exp_hp) begin
        mismatched++;
        $display("FAIL midreset_hp n=%0d got %0d want %0d", n, mif.half_period, exp_hp);
      end
    end
  endtask

  task automatic test_fast_toggle();
    gen_lo = 1; gen_hi = 1;
    repeat (40) begin
      tick();
      compared++;
      if ({mif.valid, mif.locked, mif.timeout} !== {exp_valid, exp_locked, exp_timeout}) begin
        mismatched++;
        $display("FAIL fast_flags n=%0d got v/l/t=%b%b%b want %b%b%b", n,
                 mif.valid, mif.locked, mif.timeout, exp_valid, exp_locked, exp_timeout);
      end
      compared++;
      if (mif.half_period !== exp_hp) begin
        mismatched++;
        $display("FAIL fast_hp n=%0d got %0d want %0d", n, mif.half_period, exp_hp);
      end
    end
    compared++;
    if (mif.valid !== 1'b1 || mif.half_period !== W'(1)) begin
      mismatched++;
      $display("FAIL fast_min got valid=%b hp=%0d want valid=1 hp=1", mif.valid, mif.half_period);
    end
  endtask

  task automatic test_random();
    gen_lo = 1; gen_hi = 40;
    repeat (600) begin
      tick();
      compared++;
      if ({mif.valid, mif.locked, mif.timeout} !== {exp_valid, exp_locked, exp_timeout}) begin
        mismatched++;
        $display("FAIL random_flags n=%0d got v/l/t=%b%b%b want %b%b%b", n,
                 mif.valid, mif.locked, mif.timeout, exp_valid, exp_locked, exp_timeout);
      end
      compared++;
      if (mif.half_period !== exp_hp) begin
        mismatched++;
        $display("FAIL random_hp n=%0d got %0d want %0d", n, mif.half_period, exp_hp);
      end
    end
  endtask

  initial begin
    mif.meas_in = 1'b0;
    #3;
    test_reset();
    test_steady();
    test_rate_change();
    test_jitter();
    test_timeout();
    test_reset_mid();
    test_fast_toggle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
